// File: rtl/deser_4b_pkg.sv
// Shared constants and types for the 4-bit serial-to-parallel deserializer.
//   NBITS   : assembled word width
//   state_t : controller state encoding (IDLE, COLLECT, FULL)
package deser_4b_pkg;

  localparam int NBITS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    FULL    = 2'b10
  } state_t;

endpackage

// File: rtl/deser_4b_ctrl.sv
// Handshake controller for deser_4b: state machine, bit counter and the
// in_rdy/out_val handshake outputs.
// Ports:
//   clk      : sole clock, rising edge
//   reset    : asynchronous active-low reset
//   clear    : synchronous discard of partial/held word
//   in_val   : serial bit valid
//   out_rdy  : downstream accepts the held word
//   in_rdy   : block can accept a bit this cycle
//   out_val  : assembled word valid
//   in_xfer  : a serial bit is accepted at the coming edge
//
//   state   | meaning
//   --------+--------------------------------------------
//   IDLE    | no bits held
//   COLLECT | 1..3 bits held, number held in cnt
//   FULL    | complete word held, waiting for out_rdy
module deser_4b_ctrl
  import deser_4b_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic in_val,
  input  logic out_rdy,
  output logic in_rdy,
  output logic out_val,
  output logic in_xfer
);

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       out_xfer;

  // out_val only sees registered state plus clear; in_rdy intentionally
  // looks through to out_rdy so a full word can drain and refill in one edge.
  assign out_val  = (state == FULL) && !clear;
  assign in_rdy   = !clear && ((state != FULL) || out_rdy);
  assign in_xfer  = in_val && in_rdy;
  assign out_xfer = out_val && out_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            state_nxt = COLLECT;
            cnt_nxt   = 2'd1;
          end
        end
        COLLECT: begin
          if (in_xfer) begin
            if (cnt == 2'(NBITS - 1)) begin
              state_nxt = FULL;
              cnt_nxt   = 2'd0;
            end else begin
              cnt_nxt = cnt + 2'd1;
            end
          end
        end
        FULL: begin
          if (out_xfer && in_xfer) begin
            state_nxt = COLLECT;
            cnt_nxt   = 2'd1;
          end else if (out_xfer) begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/deser_4b.sv
// 4-bit serial-to-parallel deserializer with valid/ready handshakes on both
// sides. Bits are accepted one per transfer and presented as a 4-bit word.
// Build option: define DESER_4B_MSB_FIRST_EN to place the first accepted bit
// in out_msg[3] (default: first bit lands in out_msg[0]). Timing is identical.
// Ports:
//   clk      : sole clock, rising edge
//   reset    : asynchronous active-low reset
//   clear    : synchronous discard of partial/held word
//   in_val   : serial bit valid
//   in_rdy   : block can accept in_bit this cycle
//   in_bit   : serial data bit
//   out_val  : assembled word valid
//   out_rdy  : downstream accepts the word
//   out_msg  : assembled word (defined only while out_val=1)
module deser_4b
  import deser_4b_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             in_bit,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_msg
);

  logic             in_xfer;
  logic [NBITS-1:0] shreg;

  deser_4b_ctrl u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .in_val  (in_val),
    .out_rdy (out_rdy),
    .in_rdy  (in_rdy),
    .out_val (out_val),
    .in_xfer (in_xfer)
  );

  // Every accepted bit shifts in, so after four bits the oldest has reached
  // its final position; no write pointer is needed. A refill that overlaps a
  // drain simply keeps shifting and pushes the stale bits out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
    end else if (clear) begin
      shreg <= '0;
    end else if (in_xfer) begin
`ifdef DESER_4B_MSB_FIRST_EN
      shreg <= {shreg[NBITS-2:0], in_bit};
`else
      shreg <= {in_bit, shreg[NBITS-1:1]};
`endif
    end
  end

  assign out_msg = shreg;

endmodule

// File: tb/tb_deser_4b.sv
module tb_deser_4b;

  logic       clk = 1'b0;
  logic       reset, clear, in_val, in_bit, out_rdy;
  logic       in_rdy, out_val;
  logic [3:0] out_msg;

  deser_4b dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_bit  (in_bit),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: list of accepted bits plus a held word.
  bit         m_bits[$];
  bit         m_full = 1'b0;
  logic [3:0] m_word = 4'h0;
  logic [3:0] exp_q[$];
  int         stamps[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] form_word();
    logic [3:0] w;
    w = 4'h0;
    for (int k = 0; k < 4; k++) begin
`ifdef DESER_4B_MSB_FIRST_EN
      w[3-k] = m_bits[k];
`else
      w[k] = m_bits[k];
`endif
    end
    return w;
  endfunction

  // Serial bit k needed to produce word w.
  function automatic logic bit_of(input logic [3:0] w, input int k);
`ifdef DESER_4B_MSB_FIRST_EN
    return w[3-k];
`else
    return w[k];
`endif
  endfunction

  task automatic step(input logic c, input logic v, input logic b, input logic r);
    logic e_rdy, e_val, ix, ox;
    @(negedge clk);
    clear = c; in_val = v; in_bit = b; out_rdy = r;
    #1;
    e_rdy = !c && (!m_full || r);
    e_val = m_full && !c;
    chk("in_rdy", in_rdy, e_rdy);
    chk("out_val", out_val, e_val);
    if (e_val) chk("out_msg_held", out_msg, m_word);
    ix = v && e_rdy;
    ox = e_val && r;
    if (c) begin
      m_bits.delete();
      m_full = 1'b0;
    end else begin
      if (ox) begin
        exp_q.push_back(m_word);
        m_full = 1'b0;
      end
      if (ix) begin
        m_bits.push_back(b);
        if (m_bits.size() == 4) begin
          m_word = form_word();
          m_full = 1'b1;
          m_bits.delete();
        end
      end
    end
  endtask

  task automatic send_word(input logic [3:0] w, input logic r);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, bit_of(w, k), r);
  endtask

  task automatic drain();
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: pops an expected word whenever the DUT completes an output transfer.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b1 && out_val === 1'b1 && out_rdy === 1'b1) begin
        stamps.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %0h expected none", out_msg);
        end else begin
          chk("word", out_msg, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int n0;
    logic [3:0] w;
    reset = 1'b0; clear = 1'b0; in_val = 1'b0; in_bit = 1'b0; out_rdy = 1'b0;
    #2;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_msg", out_msg, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single word 1,0,1,1
    step(0, 1, 1, 1); step(0, 1, 0, 1); step(0, 1, 1, 1); step(0, 1, 1, 1);
    @(posedge clk); #1;
    chk("single_val", out_val, 1);
`ifdef DESER_4B_MSB_FIRST_EN
    chk("single_msg", out_msg, 4'b1011);
`else
    chk("single_msg", out_msg, 4'b1101);
`endif
    drain();

    // Backpressure
    send_word(4'h6, 1'b0);
    repeat (5) step(0, 1, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Overlap: back-to-back A then 5
    n0 = stamps.size();
    send_word(4'hA, 1'b1);
    send_word(4'h5, 1'b1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("overlap_count", stamps.size() - n0, 2);
    if (stamps.size() - n0 == 2)
      chk("overlap_gap", stamps[stamps.size()-1] - stamps[stamps.size()-2], 4);

    // Gapped input
    for (int i = 0; i < 8; i++) step(0, (i % 2 == 0), 1'($urandom_range(0, 1)), 1);
    drain();

    // Clear mid-word
    step(0, 1, 1, 0); step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 1, 0);
    @(posedge clk); #1;
`ifdef DESER_4B_MSB_FIRST_EN
    chk("clear_msg", out_msg, 4'b0001);
`else
    chk("clear_msg", out_msg, 4'b1000);
`endif
    drain();

    // Async reset after 3 bits
    step(0, 1, 1, 1); step(0, 1, 1, 1); step(0, 1, 1, 1);
    @(negedge clk);
    clear = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("areset_out_val", out_val, 0);
    chk("areset_out_msg", out_msg, 0);
    m_bits.delete();
    m_full = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    send_word(4'h9, 1'b1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 6));
    end
    w = 4'($urandom_range(0, 15));
    send_word(w, 1'b1);
    repeat (3) step(0, 0, 0, 1);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
